// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the ID stage and the forwarding/hazard unit.
// ID drives the decoded instruction fields and flush. The unit returns the
// stall request, the EX operand-mux selects, the stall counter and a
// snapshot of its tracker for observation.
interface fwd_hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [3:0]       id_src1;
  logic             id_src1_used;
  logic [3:0]       id_src2;
  logic             id_src2_used;
  logic [3:0]       id_dest;
  logic             id_wb_en;
  logic             id_mem_read;
  logic             flush;
  logic             stall;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;
  logic [CNT_W-1:0] stall_count;
  // Tracker snapshot, laid out as {EX, MEM, WB} with each entry
  // packed as {valid, dest[3:0], wb_en, mem_read}.
  logic [20:0]      dbg_trk;

  modport master (
    output id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
           id_dest, id_wb_en, id_mem_read, flush,
    input  stall, sel_a, sel_b, stall_count, dbg_trk
  );

  modport slave (
    input  id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
           id_dest, id_wb_en, id_mem_read, flush,
    output stall, sel_a, sel_b, stall_count, dbg_trk
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit for the five-stage pipeline.
// It tracks the destination of each in-flight instruction in EX, MEM and WB.
// Select codes are computed while the consumer sits in ID and are registered,
// so they line up with the consumer's EX cycle.
module fwd_hazard_unit #(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_unit_if.slave hz
);

  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       wb_en;
    logic       mem_read;
  } trk_t;

  // Mux encoding consumed by the EX operand muxes; 2'b11 is never driven.
  localparam logic [1:0] SEL_RF      = 2'b00;
  localparam logic [1:0] SEL_MEM_ALU = 2'b01;
  localparam logic [1:0] SEL_WB      = 2'b10;

  trk_t             ex_q, mem_q, wb_q, ex_d;
  logic [1:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_ex, s1_mem, s2_ex, s2_mem;
  logic             hazard, stall, issue;

  // Source matching, stall decision and next-state for tracker, selects and counter.
  always_comb begin
    s1_ex  = hz.id_src1_used & ex_q.valid  & ex_q.wb_en  & (ex_q.dest  == hz.id_src1);
    s1_mem = hz.id_src1_used & mem_q.valid & mem_q.wb_en & (mem_q.dest == hz.id_src1);
    s2_ex  = hz.id_src2_used & ex_q.valid  & ex_q.wb_en  & (ex_q.dest  == hz.id_src2);
    s2_mem = hz.id_src2_used & mem_q.valid & mem_q.wb_en & (mem_q.dest == hz.id_src2);

    // With forwarding only a load still in EX cannot be bypassed in time.
    // Without forwarding, any producer still in EX or MEM must drain first.
    if (FWD_EN) hazard = (s1_ex | s2_ex) & ex_q.mem_read;
    else        hazard = s1_ex | s1_mem | s2_ex | s2_mem;

    // Flush discards the ID instruction, so it also cancels any stall it caused.
    stall = hz.id_valid & ~hz.flush & hazard;
    issue = hz.id_valid & ~hz.flush & ~stall;

    ex_d = '0;
    if (issue) begin
      ex_d.valid    = 1'b1;
      ex_d.dest     = hz.id_dest;
      ex_d.wb_en    = hz.id_wb_en;
      ex_d.mem_read = hz.id_mem_read;
    end

    // The EX producer is the newer one, so it takes priority over MEM.
    // Bubbles and the no-forwarding build always read the register file.
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (FWD_EN && issue) begin
      if (s1_ex)       sel_a_d = SEL_MEM_ALU;
      else if (s1_mem) sel_a_d = SEL_WB;
      if (s2_ex)       sel_b_d = SEL_MEM_ALU;
      else if (s2_mem) sel_b_d = SEL_WB;
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Pipeline tracker shift, registered selects and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.stall       = stall;
  assign hz.sel_a       = sel_a_q;
  assign hz.sel_b       = sel_b_q;
  assign hz.stall_count = cnt_q;
  assign hz.dbg_trk     = {ex_q, mem_q, wb_q};

endmodule
